// File: rtl/network_tx_pkt_buffer.sv
// Store-and-forward AXI4-Stream TX frame buffer: a frame is released to the MAC only
// after its last beat is stored; frames larger than the buffer are dropped whole and counted.
module network_tx_pkt_buffer #(
   parameter int DATA_W = 512,
   parameter int KEEP_W = DATA_W/8,
   parameter int USER_W = 1,
   parameter int DEPTH  = 64,
   parameter int CNT_W  = 32
) (
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic [DATA_W-1:0]       s_axis_tdata,
   input  logic [KEEP_W-1:0]       s_axis_tkeep,
   input  logic [USER_W-1:0]       s_axis_tuser,
   input  logic                    s_axis_tlast,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic [DATA_W-1:0]       m_axis_tdata,
   output logic [KEEP_W-1:0]       m_axis_tkeep,
   output logic [USER_W-1:0]       m_axis_tuser,
   output logic                    m_axis_tlast,
   output logic [$clog2(DEPTH):0]  frames_pending,
   output logic [CNT_W-1:0]        drop_count,
   output logic [CNT_W-1:0]        tx_frame_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int WW = DATA_W + KEEP_W + USER_W + 1;

   typedef enum logic {ST_PASS, ST_DROP} state_t;

   state_t            state_reg, state_next;
   logic [PW-1:0]     wr_ptr_reg, wr_ptr_next;
   logic [PW-1:0]     commit_ptr_reg, commit_ptr_next;
   logic [PW-1:0]     rd_ptr_reg;
   logic              ready_en_reg;
   logic [PW-1:0]     used, open_len;
   logic              full, open_fills;
   logic              in_ready, wr_en, commit, drop_start;

   logic [WW-1:0]     mem [DEPTH];
   logic [WW-1:0]     mem_rdata_reg;
   logic              rd_pending_reg;
   logic [WW-1:0]     out_word_reg, pf_word_reg;
   logic              out_valid_reg, pf_valid_reg;
   logic [1:0]        occ;
   logic              pop, tlast_pop, rd_issue;

   logic [PW-1:0]     frames_pending_reg;
   logic [CNT_W-1:0]  drop_count_reg, tx_frame_count_reg;

   assign used       = wr_ptr_reg - rd_ptr_reg;
   assign open_len   = wr_ptr_reg - commit_ptr_reg;
   assign full       = (used == PW'(DEPTH));
   assign open_fills = (open_len == PW'(DEPTH));

   // Ready depends only on registered state, so a same-cycle read never frees room for a write.
   always_comb begin
      state_next      = state_reg;
      wr_ptr_next     = wr_ptr_reg;
      commit_ptr_next = commit_ptr_reg;
      in_ready        = 1'b0;
      wr_en           = 1'b0;
      commit          = 1'b0;
      drop_start      = 1'b0;
      if (state_reg == ST_PASS) begin
         in_ready = ready_en_reg && !full;
         if (full && open_fills && s_axis_tvalid) begin
            state_next  = ST_DROP;
            wr_ptr_next = commit_ptr_reg;
            drop_start  = 1'b1;
         end else if (in_ready && s_axis_tvalid) begin
            wr_en       = 1'b1;
            wr_ptr_next = wr_ptr_reg + PW'(1);
            if (s_axis_tlast) begin
               commit          = 1'b1;
               commit_ptr_next = wr_ptr_reg + PW'(1);
            end
         end
      end else begin
         in_ready = ready_en_reg;
         if (s_axis_tvalid && s_axis_tlast) state_next = ST_PASS;
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_reg      <= ST_PASS;
         wr_ptr_reg     <= '0;
         commit_ptr_reg <= '0;
         ready_en_reg   <= 1'b0;
      end else begin
         state_reg      <= state_next;
         wr_ptr_reg     <= wr_ptr_next;
         commit_ptr_reg <= commit_ptr_next;
         ready_en_reg   <= 1'b1;
      end
   end

   always_ff @(posedge aclk) begin
      if (wr_en) mem[wr_ptr_reg[AW-1:0]] <= {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};
      if (rd_issue) mem_rdata_reg <= mem[rd_ptr_reg[AW-1:0]];
   end

   // Beats held downstream of memory (output, prefetch, read in flight) never exceed two,
   // which is what lets the output run one beat per clock under backpressure.
   assign pop       = out_valid_reg && m_axis_tready;
   assign tlast_pop = pop && out_word_reg[WW-1];
   assign occ       = 2'(out_valid_reg) + 2'(pf_valid_reg) + 2'(rd_pending_reg);
   assign rd_issue  = (rd_ptr_reg != commit_ptr_reg) && ((occ - 2'(pop)) <= 2'd1);

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         rd_ptr_reg     <= '0;
         rd_pending_reg <= 1'b0;
         out_valid_reg  <= 1'b0;
         pf_valid_reg   <= 1'b0;
      end else begin
         rd_pending_reg <= rd_issue;
         if (rd_issue) rd_ptr_reg <= rd_ptr_reg + PW'(1);
         if (!out_valid_reg || pop) begin
            if (pf_valid_reg) begin
               out_word_reg  <= pf_word_reg;
               out_valid_reg <= 1'b1;
               pf_word_reg   <= mem_rdata_reg;
               pf_valid_reg  <= rd_pending_reg;
            end else if (rd_pending_reg) begin
               out_word_reg  <= mem_rdata_reg;
               out_valid_reg <= 1'b1;
            end else begin
               out_valid_reg <= 1'b0;
            end
         end else if (rd_pending_reg) begin
            pf_word_reg  <= mem_rdata_reg;
            pf_valid_reg <= 1'b1;
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         frames_pending_reg <= '0;
         drop_count_reg     <= '0;
         tx_frame_count_reg <= '0;
      end else begin
         if (commit && !tlast_pop)
            frames_pending_reg <= frames_pending_reg + PW'(1);
         else if (!commit && tlast_pop)
            frames_pending_reg <= frames_pending_reg - PW'(1);
         if (drop_start && (drop_count_reg != {CNT_W{1'b1}}))
            drop_count_reg <= drop_count_reg + CNT_W'(1);
         if (tlast_pop)
            tx_frame_count_reg <= tx_frame_count_reg + CNT_W'(1);
      end
   end

   assign s_axis_tready  = in_ready;
   assign m_axis_tvalid  = out_valid_reg;
   assign m_axis_tdata   = out_word_reg[DATA_W-1:0];
   assign m_axis_tkeep   = out_word_reg[DATA_W +: KEEP_W];
   assign m_axis_tuser   = out_word_reg[DATA_W+KEEP_W +: USER_W];
   assign m_axis_tlast   = out_word_reg[WW-1];
   assign frames_pending = frames_pending_reg;
   assign drop_count     = drop_count_reg;
   assign tx_frame_count = tx_frame_count_reg;

endmodule

// File: tb/tb_network_tx_pkt_buffer.sv
// Directed testbench for network_tx_pkt_buffer: per-feature tasks with inline checks
// against beats generated by mk_beat().
module tb_network_tx_pkt_buffer;
   localparam int DATA_W = 32;
   localparam int KEEP_W = 4;
   localparam int USER_W = 1;
   localparam int DEPTH  = 64;
   localparam int CNT_W  = 32;
   localparam int BW     = DATA_W + KEEP_W + USER_W + 1;

   logic              clk = 1'b0;
   logic              aresetn = 1'b0;
   logic              s_tvalid = 1'b0, s_tready;
   logic [DATA_W-1:0] s_tdata = '0;
   logic [KEEP_W-1:0] s_tkeep = '0;
   logic [USER_W-1:0] s_tuser = '0;
   logic              s_tlast = 1'b0;
   logic              m_tvalid, m_tready = 1'b0;
   logic [DATA_W-1:0] m_tdata;
   logic [KEEP_W-1:0] m_tkeep;
   logic [USER_W-1:0] m_tuser;
   logic              m_tlast;
   logic [$clog2(DEPTH):0] frames_pending;
   logic [CNT_W-1:0]  drop_count, tx_frame_count;

   network_tx_pkt_buffer #(
      .DATA_W(DATA_W), .KEEP_W(KEEP_W), .USER_W(USER_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
   ) dut (
      .aclk(clk), .aresetn(aresetn),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
      .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast),
      .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
      .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser), .m_axis_tlast(m_tlast),
      .frames_pending(frames_pending), .drop_count(drop_count), .tx_frame_count(tx_frame_count)
   );

   always #5 clk = ~clk;

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt++;

   int errors = 0;
   int checks = 0;
   logic [BW-1:0] rx_q[$];
   int tlast_edge, first_valid_edge, idle_cnt, hold_err, stall_cnt, pend_peak;
   bit tx_timeout, rx_timeout;

   always @(negedge clk) if (int'(frames_pending) > pend_peak) pend_peak = int'(frames_pending);

   function automatic logic [BW-1:0] mk_beat(input int fid, input int b, input int len);
      logic [DATA_W-1:0] d;
      logic [KEEP_W-1:0] k;
      logic [USER_W-1:0] u;
      logic              l;
      d = DATA_W'(32'hC0DE_0000 ^ (fid << 8) ^ b);
      k = KEEP_W'(fid * 3 + b + 1);
      u = USER_W'((fid + b) & 1);
      l = (b == len - 1);
      return {l, u, k, d};
   endfunction

   task automatic clear_stats();
      rx_q.delete();
      idle_cnt = 0; hold_err = 0; stall_cnt = 0; pend_peak = 0;
      tx_timeout = 0; rx_timeout = 0;
      tlast_edge = -100; first_valid_edge = -1;
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      aresetn = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0;
      repeat (n) @(negedge clk);
      aresetn = 1'b1;
   endtask

   task automatic send_frame(input int fid, input int len, input bit gaps);
      int b = 0;
      int cyc = 0;
      int waitc = 0;
      while (b < len) begin
         @(negedge clk);
         {s_tlast, s_tuser, s_tkeep, s_tdata} = mk_beat(fid, b, len);
         s_tvalid = !(gaps && (cyc % 3 == 2));
         cyc++;
         if (s_tvalid && s_tready) begin
            if (b == len - 1) tlast_edge = cyc_cnt + 1;
            b++;
            waitc = 0;
         end else begin
            if (s_tvalid) stall_cnt++;
            waitc++;
            if (waitc > 3000) begin
               tx_timeout = 1;
               break;
            end
         end
      end
      @(negedge clk);
      s_tvalid = 1'b0;
      $display("tx frame %0d: %0d beats offered", fid, len);
   endtask

   task automatic receive(input int nbeats, input bit rnd, input int budget);
      int got = 0;
      int n = 0;
      bit stalled = 0, seen = 0, started = 0;
      logic [BW:0] cur, held;
      held = '0;
      while (got < nbeats && n < budget) begin
         @(negedge clk);
         n++;
         cur = {m_tvalid, m_tlast, m_tuser, m_tkeep, m_tdata};
         if (stalled && cur !== held) hold_err++;
         if (!seen && m_tvalid) begin
            seen = 1;
            first_valid_edge = cyc_cnt;
         end
         if (started && !m_tvalid) idle_cnt++;
         m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (m_tvalid && m_tready) begin
            rx_q.push_back(cur[BW-1:0]);
            got++;
            started = 1;
            stalled = 0;
         end else begin
            stalled = m_tvalid;
            held = cur;
         end
      end
      if (got < nbeats) rx_timeout = 1;
      @(negedge clk);
      m_tready = 1'b0;
      $display("rx: %0d of %0d beats collected in %0d cycles", got, nbeats, n);
   endtask

   function automatic logic [BW-1:0] rx_at(input int i);
      logic [BW-1:0] v;
      v = 'x;
      if (i < rx_q.size()) v = rx_q[i];
      return v;
   endfunction

   task automatic test_reset();
      aresetn = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_s_tready: got %b want 0", s_tready); end
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid: got %b want 0", m_tvalid); end
      checks++; if (frames_pending !== '0) begin errors++; $display("FAIL reset_frames_pending: got %0d want 0", frames_pending); end
      checks++; if (drop_count !== '0) begin errors++; $display("FAIL reset_drop_count: got %0d want 0", drop_count); end
      checks++; if (tx_frame_count !== '0) begin errors++; $display("FAIL reset_tx_frame_count: got %0d want 0", tx_frame_count); end
      aresetn = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL post_reset_s_tready: got %b want 1", s_tready); end
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL post_reset_m_tvalid: got %b want 0", m_tvalid); end
      $display("test_reset done");
   endtask

   task automatic test_single_frame();
      clear_stats(); do_reset(2);
      fork
         send_frame(1, 3, 0);
         receive(3, 0, 200);
      join
      checks++; if (rx_q.size() != 3) begin errors++; $display("FAIL single_count: got %0d beats want 3", rx_q.size()); end
      checks++; if (first_valid_edge - tlast_edge != 2) begin errors++; $display("FAIL single_latency: got %0d cycles want 2", first_valid_edge - tlast_edge); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (rx_at(i) !== mk_beat(1, i, 3)) begin errors++; $display("FAIL single_beat%0d: got %h want %h", i, rx_at(i), mk_beat(1, i, 3)); end
      end
      checks++; if (idle_cnt != 0) begin errors++; $display("FAIL single_bubbles: got %0d want 0", idle_cnt); end
      checks++; if (tx_frame_count !== 32'd1) begin errors++; $display("FAIL single_tx_count: got %0d want 1", tx_frame_count); end
      checks++; if (frames_pending !== '0) begin errors++; $display("FAIL single_pending: got %0d want 0", frames_pending); end
   endtask

   task automatic test_gappy_input();
      clear_stats(); do_reset(2);
      fork
         send_frame(2, 8, 1);
         receive(8, 0, 300);
      join
      checks++; if (rx_q.size() != 8) begin errors++; $display("FAIL gappy_count: got %0d beats want 8", rx_q.size()); end
      checks++; if (first_valid_edge - tlast_edge != 2) begin errors++; $display("FAIL gappy_latency: got %0d cycles want 2", first_valid_edge - tlast_edge); end
      checks++; if (idle_cnt != 0) begin errors++; $display("FAIL gappy_bubbles: got %0d want 0", idle_cnt); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (rx_at(i) !== mk_beat(2, i, 8)) begin errors++; $display("FAIL gappy_beat%0d: got %h want %h", i, rx_at(i), mk_beat(2, i, 8)); end
      end
      checks++; if (tx_frame_count !== 32'd1) begin errors++; $display("FAIL gappy_tx_count: got %0d want 1", tx_frame_count); end
   endtask

   task automatic test_oversize_drop();
      clear_stats(); do_reset(2);
      fork
         begin
            send_frame(10, 70, 0);
            send_frame(11, 4, 0);
         end
         receive(4, 0, 2000);
      join
      checks++; if (tx_timeout) begin errors++; $display("FAIL drop_tx_timeout: got 1 want 0"); end
      checks++; if (drop_count !== 32'd1) begin errors++; $display("FAIL drop_count: got %0d want 1", drop_count); end
      checks++; if (stall_cnt != 1) begin errors++; $display("FAIL drop_s_tready_stalls: got %0d want 1", stall_cnt); end
      checks++; if (rx_q.size() != 4) begin errors++; $display("FAIL drop_rx_count: got %0d want 4", rx_q.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rx_at(i) !== mk_beat(11, i, 4)) begin errors++; $display("FAIL drop_beat%0d: got %h want %h", i, rx_at(i), mk_beat(11, i, 4)); end
      end
      checks++; if (pend_peak != 1) begin errors++; $display("FAIL drop_pending_peak: got %0d want 1", pend_peak); end
      checks++; if (tx_frame_count !== 32'd1) begin errors++; $display("FAIL drop_tx_count: got %0d want 1", tx_frame_count); end
      repeat (5) @(negedge clk);
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL drop_no_extra: got m_tvalid=%b want 0", m_tvalid); end
   endtask

   task automatic test_back_to_back();
      clear_stats(); do_reset(2);
      m_tready = 1'b0;
      fork
         begin
            send_frame(20, 40, 0);
            send_frame(21, 40, 0);
         end
         begin
            repeat (150) @(negedge clk);
            checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL full_s_tready: got %b want 0", s_tready); end
            checks++; if (frames_pending !== 7'd1) begin errors++; $display("FAIL full_pending: got %0d want 1", frames_pending); end
            checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL full_m_tvalid: got %b want 1", m_tvalid); end
            receive(80, 0, 1000);
         end
      join
      checks++; if (rx_q.size() != 80) begin errors++; $display("FAIL b2b_count: got %0d want 80", rx_q.size()); end
      for (int i = 0; i < 80; i++) begin
         checks++;
         if (rx_at(i) !== mk_beat(20 + i / 40, i % 40, 40)) begin
            errors++; $display("FAIL b2b_beat%0d: got %h want %h", i, rx_at(i), mk_beat(20 + i / 40, i % 40, 40));
         end
      end
      checks++; if (idle_cnt != 0) begin errors++; $display("FAIL b2b_bubbles: got %0d want 0", idle_cnt); end
      checks++; if (drop_count !== '0) begin errors++; $display("FAIL b2b_drop_count: got %0d want 0", drop_count); end
      checks++; if (tx_frame_count !== 32'd2) begin errors++; $display("FAIL b2b_tx_count: got %0d want 2", tx_frame_count); end
      checks++; if (frames_pending !== '0) begin errors++; $display("FAIL b2b_pending: got %0d want 0", frames_pending); end
   endtask

   task automatic test_random_ready();
      int lens[20];
      int total = 0;
      int k = 0;
      clear_stats(); do_reset(2);
      for (int f = 0; f < 20; f++) begin
         lens[f] = (f == 0) ? 1 : (f < 3) ? 64 : int'($urandom_range(1, 64));
         total += lens[f];
      end
      fork
         begin
            for (int f = 0; f < 20; f++) send_frame(40 + f, lens[f], 0);
         end
         receive(total, 1, 20000);
      join
      checks++; if (hold_err != 0) begin errors++; $display("FAIL rand_hold_stable: got %0d violations want 0", hold_err); end
      checks++; if (rx_q.size() != total) begin errors++; $display("FAIL rand_count: got %0d want %0d", rx_q.size(), total); end
      for (int f = 0; f < 20; f++) begin
         for (int b = 0; b < lens[f]; b++) begin
            checks++;
            if (rx_at(k) !== mk_beat(40 + f, b, lens[f])) begin
               errors++; $display("FAIL rand_f%0d_b%0d: got %h want %h", f, b, rx_at(k), mk_beat(40 + f, b, lens[f]));
            end
            k++;
         end
      end
      checks++; if (tx_frame_count !== 32'd20) begin errors++; $display("FAIL rand_tx_count: got %0d want 20", tx_frame_count); end
      checks++; if (drop_count !== '0) begin errors++; $display("FAIL rand_drop_count: got %0d want 0", drop_count); end
      checks++; if (frames_pending !== '0) begin errors++; $display("FAIL rand_pending: got %0d want 0", frames_pending); end
   endtask

   task automatic test_mid_reset();
      int b = 0;
      int waitc = 0;
      clear_stats(); do_reset(2);
      m_tready = 1'b0;
      send_frame(30, 3, 0);
      while (b < 2 && waitc < 100) begin
         @(negedge clk);
         {s_tlast, s_tuser, s_tkeep, s_tdata} = mk_beat(31, b, 8);
         s_tvalid = 1'b1;
         if (s_tready) b++; else waitc++;
      end
      @(negedge clk);
      s_tvalid = 1'b0;
      receive(1, 0, 50);
      checks++; if (frames_pending !== 7'd1) begin errors++; $display("FAIL pre_reset_pending: got %0d want 1", frames_pending); end
      aresetn = 1'b0;
      @(negedge clk);
      aresetn = 1'b1;
      checks++; if (frames_pending !== '0) begin errors++; $display("FAIL midrst_pending: got %0d want 0", frames_pending); end
      checks++; if (drop_count !== '0) begin errors++; $display("FAIL midrst_drop_count: got %0d want 0", drop_count); end
      checks++; if (tx_frame_count !== '0) begin errors++; $display("FAIL midrst_tx_count: got %0d want 0", tx_frame_count); end
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_m_tvalid: got %b want 0", m_tvalid); end
      rx_q.delete();
      fork
         send_frame(32, 2, 0);
         receive(2, 0, 200);
      join
      checks++; if (rx_q.size() != 2) begin errors++; $display("FAIL midrst_rx_count: got %0d want 2", rx_q.size()); end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (rx_at(i) !== mk_beat(32, i, 2)) begin errors++; $display("FAIL midrst_beat%0d: got %h want %h", i, rx_at(i), mk_beat(32, i, 2)); end
      end
      checks++; if (tx_frame_count !== 32'd1) begin errors++; $display("FAIL midrst_tx_after: got %0d want 1", tx_frame_count); end
      repeat (5) @(negedge clk);
      checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_stale: got m_tvalid=%b want 0", m_tvalid); end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_gappy_input();
      test_oversize_drop();
      test_back_to_back();
      test_random_ready();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
